// File: rtl/mem_lsu_if.sv
// mem_lsu_if: execute-stage, data-bus and writeback/exception signal bundle for mem_lsu
//   slave  modport: the LSU side (takes ex_*/flush_i/bus responses, drives ready/bus request/wb/exc)
//   master modport: the surrounding pipeline + memory side
interface mem_lsu_if #(parameter int XLEN = 32);
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic              ex_load_i;
    logic              ex_store_i;
    logic [2:0]        ex_funct3_i;
    logic [XLEN-1:0]   ex_addr_i;
    logic [XLEN-1:0]   ex_wdata_i;
    logic [4:0]        ex_rd_addr_i;
    logic              ex_rd_we_i;
    logic [XLEN-1:0]   ex_rd_wdata_i;
    logic              flush_i;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [XLEN-1:0]   bus_addr_o;
    logic [XLEN-1:0]   bus_wdata_o;
    logic [XLEN/8-1:0] bus_be_o;
    logic              bus_ack_i;
    logic              bus_err_i;
    logic [XLEN-1:0]   bus_rdata_i;
    logic              wb_valid_o;
    logic [4:0]        wb_rd_addr_o;
    logic              wb_rd_we_o;
    logic [XLEN-1:0]   wb_rd_wdata_o;
    logic              exc_valid_o;
    logic [3:0]        exc_cause_o;
    logic [XLEN-1:0]   exc_addr_o;

    modport slave (
        input  ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_addr_i, ex_wdata_i,
               ex_rd_addr_i, ex_rd_we_i, ex_rd_wdata_i, flush_i, bus_ack_i, bus_err_i, bus_rdata_i,
        output ex_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
               wb_valid_o, wb_rd_addr_o, wb_rd_we_o, wb_rd_wdata_o, exc_valid_o, exc_cause_o, exc_addr_o
    );

    modport master (
        output ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_addr_i, ex_wdata_i,
               ex_rd_addr_i, ex_rd_we_i, ex_rd_wdata_i, flush_i, bus_ack_i, bus_err_i, bus_rdata_i,
        input  ex_ready_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
               wb_valid_o, wb_rd_addr_o, wb_rd_we_o, wb_rd_wdata_o, exc_valid_o, exc_cause_o, exc_addr_o
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit issuing one data-bus access at a time, with writeback and access faults
//   clk, rstn (async, active-low), io (mem_lsu_if.slave: ex handshake, data bus, wb/exc outputs)
//   XLEN 32/64; TIMEOUT bus cycles without ack before a fault (0 = never)
//   MEM_LSU_MISALIGN_SPLIT_EN: accesses crossing a bus word are split into two beats;
//   undefined, any misaligned access faults without a bus request
module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 0
) (
    input logic      clk,
    input logic      rstn,
    mem_lsu_if.slave io
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int DW = 2 * XLEN;
    localparam int BW = 2 * NB;

    typedef enum logic [1:0] {IDLE, BUS1, BUS2} state_t;
    state_t r_state, w_state_n;

    logic [31:0]     r_tcnt;
    logic [XLEN-1:0] r_base, r_addr, r_lo;
    logic [BW-1:0]   r_be2;
    logic [DW-1:0]   r_wd2;
    logic [2:0]      r_f3;
    logic [3:0]      r_off;
    logic [4:0]      r_rd_addr;
    logic            r_we, r_rd_we, r_kill;
    logic            r_wb_valid, r_wb_rd_we, r_exc_valid;
    logic [4:0]      r_wb_rd_addr;
    logic [XLEN-1:0] r_wb_rd_wdata, r_exc_addr;
    logic [3:0]      r_exc_cause;

    logic            w_ready, w_acc, w_mem, w_illegal, w_mis_fault, w_kill, w_split, w_tmo, w_sgn;
    logic [3:0]      w_nb, w_off, w_rnb;
    logic [15:0]     w_bm;
    logic [BW-1:0]   w_be2;
    logic [DW-1:0]   w_dm, w_wd2, w_raw, w_rm;
    logic [XLEN-1:0] w_ld;

    // Decode of the offered access; be/wdata are built over two bus words so a split needs no extra logic
    always_comb begin
        w_nb      = 4'd1 << io.ex_funct3_i[1:0];
        w_off     = 4'(io.ex_addr_i[OW-1:0]);
        w_mem     = io.ex_load_i || io.ex_store_i;
        w_illegal = (XLEN == 32) ? (io.ex_funct3_i == 3'b011 || io.ex_funct3_i[2:1] == 2'b11)
                                 : (io.ex_funct3_i == 3'b111);
        w_bm      = (16'd1 << w_nb) - 16'd1;
        w_be2     = BW'(w_bm) << w_off;
        w_dm      = (DW'(1) << {w_nb, 3'b000}) - DW'(1);
        w_wd2     = (DW'(io.ex_wdata_i) & w_dm) << {w_off, 3'b000};
    end

`ifdef MEM_LSU_MISALIGN_SPLIT_EN
    assign w_mis_fault = 1'b0;
`else
    assign w_mis_fault = (w_off & (w_nb - 4'd1)) != 4'd0;
`endif

    assign w_ready = rstn && r_state == IDLE && !io.flush_i;
    assign w_acc   = w_ready && io.ex_valid_i;
    assign w_kill  = r_kill || io.flush_i;
    assign w_split = |r_be2[BW-1:NB];
    assign w_tmo   = (TIMEOUT != 0) && (r_tcnt == 32'(TIMEOUT - 1));

    // Load extraction: second beat supplies the upper word of the merged pair
    always_comb begin
        w_rnb = 4'd1 << r_f3[1:0];
        w_raw = (r_state == BUS2 ? {io.bus_rdata_i, r_lo} : DW'(io.bus_rdata_i)) >> {r_off, 3'b000};
        w_rm  = (DW'(1) << {w_rnb, 3'b000}) - DW'(1);
        w_sgn = !r_f3[2] && |(w_raw & (w_rm ^ (w_rm >> 1)));
        w_ld  = (w_raw[XLEN-1:0] & w_rm[XLEN-1:0]) | ({XLEN{w_sgn}} & ~w_rm[XLEN-1:0]);
    end

    // Timeout counter restarts on every state change, so each beat gets its own budget
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_tcnt  <= (w_state_n != r_state || r_state == IDLE) ? '0 : r_tcnt + 32'd1;
        end
    end

    // A killed load never starts its second beat; a killed store still completes both
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = (w_acc && w_mem && !w_illegal && !w_mis_fault) ? BUS1 : IDLE;
            BUS1:    w_state_n = io.bus_err_i ? IDLE :
                                 io.bus_ack_i ? ((w_split && !(w_kill && !r_we)) ? BUS2 : IDLE) :
                                 w_tmo ? IDLE : BUS1;
            BUS2:    w_state_n = (io.bus_ack_i || io.bus_err_i || w_tmo) ? IDLE : BUS2;
            default: w_state_n = IDLE;
        endcase
    end

    always_comb begin
        io.ex_ready_o    = w_ready;
        io.bus_req_o     = r_state != IDLE;
        io.bus_we_o      = r_we;
        io.bus_addr_o    = r_state == BUS2 ? r_base + XLEN'(NB) : r_base;
        io.bus_be_o      = r_state == BUS2 ? r_be2[BW-1:NB] : r_be2[NB-1:0];
        io.bus_wdata_o   = r_state == BUS2 ? r_wd2[DW-1:XLEN] : r_wd2[XLEN-1:0];
        io.wb_valid_o    = r_wb_valid;
        io.wb_rd_addr_o  = r_wb_rd_addr;
        io.wb_rd_we_o    = r_wb_rd_we;
        io.wb_rd_wdata_o = r_wb_rd_wdata;
        io.exc_valid_o   = r_exc_valid;
        io.exc_cause_o   = r_exc_cause;
        io.exc_addr_o    = r_exc_addr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base        <= '0;
            r_addr        <= '0;
            r_lo          <= '0;
            r_be2         <= '0;
            r_wd2         <= '0;
            r_f3          <= '0;
            r_off         <= '0;
            r_rd_addr     <= '0;
            r_we          <= 1'b0;
            r_rd_we       <= 1'b0;
            r_kill        <= 1'b0;
            r_wb_valid    <= 1'b0;
            r_wb_rd_addr  <= '0;
            r_wb_rd_we    <= 1'b0;
            r_wb_rd_wdata <= '0;
            r_exc_valid   <= 1'b0;
            r_exc_cause   <= '0;
            r_exc_addr    <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (w_acc && !w_mem) begin
                    r_wb_valid    <= 1'b1;
                    r_wb_rd_addr  <= io.ex_rd_addr_i;
                    r_wb_rd_we    <= io.ex_rd_we_i;
                    r_wb_rd_wdata <= io.ex_rd_wdata_i;
                end else if (w_acc && (w_illegal || w_mis_fault)) begin
                    r_exc_valid <= 1'b1;
                    r_exc_cause <= w_illegal ? (io.ex_store_i ? 4'd7 : 4'd5) : (io.ex_store_i ? 4'd6 : 4'd4);
                    r_exc_addr  <= io.ex_addr_i;
                end else if (w_acc) begin
                    r_base    <= io.ex_addr_i & ~XLEN'(NB - 1);
                    r_addr    <= io.ex_addr_i;
                    r_be2     <= w_be2;
                    r_wd2     <= w_wd2;
                    r_f3      <= io.ex_funct3_i;
                    r_off     <= w_off;
                    r_rd_addr <= io.ex_rd_addr_i;
                    r_we      <= io.ex_store_i;
                    r_rd_we   <= io.ex_rd_we_i && !io.ex_store_i;
                    r_kill    <= 1'b0;
                end
            end else begin
                r_kill <= w_kill;
                if (w_state_n == BUS2 && r_state == BUS1)
                    r_lo <= io.bus_rdata_i;
                if (w_state_n == IDLE && !w_kill) begin
                    if (io.bus_ack_i && !io.bus_err_i) begin
                        r_wb_valid    <= 1'b1;
                        r_wb_rd_addr  <= r_rd_addr;
                        r_wb_rd_we    <= r_rd_we;
                        r_wb_rd_wdata <= r_we ? '0 : w_ld;
                    end else begin
                        r_exc_valid <= 1'b1;
                        r_exc_cause <= r_we ? 4'd7 : 4'd5;
                        r_exc_addr  <= r_addr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu (XLEN=32, TIMEOUT=8)
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_lsu_if #(.XLEN(32)) bus ();

    mem_lsu #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .io   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.ex_valid_i  = 1'b1;
        bus.ex_load_i   = ld;
        bus.ex_store_i  = st;
        bus.ex_funct3_i = f3;
        bus.ex_addr_i   = a;
        bus.ex_wdata_i  = wd;
        step();
        bus.ex_valid_i  = 1'b0;
        bus.ex_load_i   = 1'b0;
        bus.ex_store_i  = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = rd;
        step();
        bus.bus_ack_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.ex_valid_i = 0; bus.ex_load_i = 0; bus.ex_store_i = 0; bus.ex_funct3_i = 0;
        bus.ex_addr_i = 0; bus.ex_wdata_i = 0; bus.ex_rd_addr_i = 0; bus.ex_rd_we_i = 0;
        bus.ex_rd_wdata_i = 0; bus.flush_i = 0; bus.bus_ack_i = 0; bus.bus_err_i = 0;
        bus.bus_rdata_i = 0;
        step(); step();
        chk("rst_ready", bus.ex_ready_o, 0);
        chk("rst_req", bus.bus_req_o, 0);
        chk("rst_wb", bus.wb_valid_o, 0);
        chk("rst_exc", bus.exc_valid_o, 0);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", bus.ex_ready_o, 1);

        // non-memory instruction
        bus.ex_rd_addr_i = 5'd5; bus.ex_rd_we_i = 1'b1; bus.ex_rd_wdata_i = 32'hDEADBEEF;
        issue(0, 0, 3'b000, 32'h0, 32'h0);
        chk("nm_wb", bus.wb_valid_o, 1);
        chk("nm_rd", bus.wb_rd_addr_o, 5);
        chk("nm_data", bus.wb_rd_wdata_o, 32'hDEADBEEF);
        chk("nm_we", bus.wb_rd_we_o, 1);
        chk("nm_req", bus.bus_req_o, 0);
        step();
        chk("nm_pulse", bus.wb_valid_o, 0);

        // LB 0x1003 with one wait cycle
        bus.ex_rd_addr_i = 5'd7;
        issue(1, 0, 3'b000, 32'h1003, 32'h0);
        chk("lb_req", bus.bus_req_o, 1);
        chk("lb_addr", bus.bus_addr_o, 32'h1000);
        chk("lb_be", bus.bus_be_o, 4'b1000);
        chk("lb_we", bus.bus_we_o, 0);
        chk("lb_ready", bus.ex_ready_o, 0);
        step();
        chk("lb_hold_req", bus.bus_req_o, 1);
        chk("lb_hold_addr", bus.bus_addr_o, 32'h1000);
        chk("lb_hold_be", bus.bus_be_o, 4'b1000);
        ack(32'h80000000);
        chk("lb_wb", bus.wb_valid_o, 1);
        chk("lb_data", bus.wb_rd_wdata_o, 32'hFFFFFF80);
        chk("lb_rd", bus.wb_rd_addr_o, 7);
        chk("lb_rdwe", bus.wb_rd_we_o, 1);
        chk("lb_exc", bus.exc_valid_o, 0);
        chk("lb_req_done", bus.bus_req_o, 0);
        chk("lb_ready_done", bus.ex_ready_o, 1);
        step();
        chk("lb_wb_pulse", bus.wb_valid_o, 0);

        // LBU 0x1003, minimum latency
        issue(1, 0, 3'b100, 32'h1003, 32'h0);
        ack(32'h80000000);
        chk("lbu_wb", bus.wb_valid_o, 1);
        chk("lbu_data", bus.wb_rd_wdata_o, 32'h00000080);

        // SH 0x1234ABCD at 0x2002
        issue(0, 1, 3'b001, 32'h2002, 32'h1234ABCD);
        chk("sh_addr", bus.bus_addr_o, 32'h2000);
        chk("sh_be", bus.bus_be_o, 4'b1100);
        chk("sh_wdata", bus.bus_wdata_o, 32'hABCD0000);
        chk("sh_we", bus.bus_we_o, 1);
        ack(32'h0);
        chk("sh_wb", bus.wb_valid_o, 1);
        chk("sh_rdwe", bus.wb_rd_we_o, 0);

`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        // LW 0x3002 split into two beats
        issue(1, 0, 3'b010, 32'h3002, 32'h0);
        chk("lw_b1_addr", bus.bus_addr_o, 32'h3000);
        chk("lw_b1_be", bus.bus_be_o, 4'b1100);
        ack(32'h55667788);
        chk("lw_b2_req", bus.bus_req_o, 1);
        chk("lw_b2_addr", bus.bus_addr_o, 32'h3004);
        chk("lw_b2_be", bus.bus_be_o, 4'b0011);
        chk("lw_b2_wb", bus.wb_valid_o, 0);
        ack(32'h11223344);
        chk("lw_split_wb", bus.wb_valid_o, 1);
        chk("lw_split_data", bus.wb_rd_wdata_o, 32'h33445566);
        // LH 0x1001 stays in one word
        issue(1, 0, 3'b001, 32'h1001, 32'h0);
        chk("lh_in_be", bus.bus_be_o, 4'b0110);
        ack(32'h00ABCD00);
        chk("lh_in_data", bus.wb_rd_wdata_o, 32'hFFFFABCD);
`else
        issue(1, 0, 3'b010, 32'h3002, 32'h0);
        chk("lw_mis_exc", bus.exc_valid_o, 1);
        chk("lw_mis_cause", bus.exc_cause_o, 4);
        chk("lw_mis_addr", bus.exc_addr_o, 32'h3002);
        chk("lw_mis_req", bus.bus_req_o, 0);
        chk("lw_mis_wb", bus.wb_valid_o, 0);
        issue(0, 1, 3'b001, 32'h3001, 32'h0);
        chk("sh_mis_cause", bus.exc_cause_o, 6);
        chk("sh_mis_req", bus.bus_req_o, 0);
`endif

        // illegal sizes
        issue(1, 0, 3'b011, 32'h10, 32'h0);
        chk("ld_ill_exc", bus.exc_valid_o, 1);
        chk("ld_ill_cause", bus.exc_cause_o, 5);
        chk("ld_ill_req", bus.bus_req_o, 0);
        issue(0, 1, 3'b110, 32'h10, 32'h0);
        chk("st_ill_cause", bus.exc_cause_o, 7);
        chk("st_ill_req", bus.bus_req_o, 0);

        // bus errors
        issue(1, 0, 3'b010, 32'h6000, 32'h0);
        bus.bus_err_i = 1'b1; step(); bus.bus_err_i = 1'b0;
        chk("lerr_exc", bus.exc_valid_o, 1);
        chk("lerr_cause", bus.exc_cause_o, 5);
        chk("lerr_addr", bus.exc_addr_o, 32'h6000);
        chk("lerr_wb", bus.wb_valid_o, 0);
        chk("lerr_req", bus.bus_req_o, 0);
        issue(0, 1, 3'b010, 32'h6004, 32'h0);
        bus.bus_err_i = 1'b1; step(); bus.bus_err_i = 1'b0;
        chk("serr_cause", bus.exc_cause_o, 7);
        chk("serr_wb", bus.wb_valid_o, 0);
        step();
        chk("serr_pulse", bus.exc_valid_o, 0);

        // timeout after 8 bus cycles
        issue(1, 0, 3'b010, 32'h4000, 32'h0);
        repeat (7) step();
        chk("to_req_hold", bus.bus_req_o, 1);
        step();
        chk("to_req", bus.bus_req_o, 0);
        chk("to_exc", bus.exc_valid_o, 1);
        chk("to_cause", bus.exc_cause_o, 5);
        chk("to_ready", bus.ex_ready_o, 1);

        // ack on the timeout cycle wins
        issue(1, 0, 3'b010, 32'h4000, 32'h0);
        repeat (7) step();
        ack(32'hCAFEF00D);
        chk("tie_wb", bus.wb_valid_o, 1);
        chk("tie_data", bus.wb_rd_wdata_o, 32'hCAFEF00D);
        chk("tie_exc", bus.exc_valid_o, 0);

        // flush of a load in BUS1
        issue(1, 0, 3'b010, 32'h5000, 32'h0);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_ready", bus.ex_ready_o, 0);
        step();
        bus.flush_i = 1'b0;
        step(); step();
        chk("fl_req_hold", bus.bus_req_o, 1);
        ack(32'h11111111);
        chk("fl_wb", bus.wb_valid_o, 0);
        chk("fl_exc", bus.exc_valid_o, 0);
        chk("fl_req", bus.bus_req_o, 0);
        chk("fl_idle", bus.ex_ready_o, 1);
        step();
        chk("fl_wb_late", bus.wb_valid_o, 0);

        // flush of a store: the access still completes
        issue(0, 1, 3'b010, 32'h5004, 32'hA5A5A5A5);
        bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
        chk("fs_req", bus.bus_req_o, 1);
        chk("fs_we", bus.bus_we_o, 1);
        chk("fs_wdata", bus.bus_wdata_o, 32'hA5A5A5A5);
        step();
        ack(32'h0);
        chk("fs_wb", bus.wb_valid_o, 0);
        chk("fs_req_done", bus.bus_req_o, 0);

        // flush while an instruction is offered in IDLE
        bus.flush_i = 1'b1; bus.ex_valid_i = 1'b1; bus.ex_rd_addr_i = 5'd9;
        #1;
        chk("fi_ready", bus.ex_ready_o, 0);
        step();
        bus.flush_i = 1'b0; bus.ex_valid_i = 1'b0;
        chk("fi_wb", bus.wb_valid_o, 0);

        // reset in the middle of an access
`ifdef MEM_LSU_MISALIGN_SPLIT_EN
        issue(1, 0, 3'b010, 32'h3002, 32'h0);
        ack(32'h55667788);
`else
        issue(1, 0, 3'b010, 32'h7000, 32'h0);
`endif
        chk("rr_req_before", bus.bus_req_o, 1);
        rstn = 1'b0;
        #1;
        chk("rr_req", bus.bus_req_o, 0);
        chk("rr_ready", bus.ex_ready_o, 0);
        chk("rr_wb", bus.wb_valid_o, 0);
        chk("rr_exc", bus.exc_valid_o, 0);
        chk("rr_addr", bus.bus_addr_o, 0);
        chk("rr_be", bus.bus_be_o, 0);
        step();
        rstn = 1'b1;
        step();
        chk("rr_nowb", bus.wb_valid_o, 0);
        issue(1, 0, 3'b010, 32'h7000, 32'h0);
        chk("rr_new_addr", bus.bus_addr_o, 32'h7000);
        ack(32'h12345678);
        chk("rr_new_wb", bus.wb_valid_o, 1);
        chk("rr_new_data", bus.wb_rd_wdata_o, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, 32, data/address width; legal values 32 or 64.
REQ-002 Parameter TIMEOUT, 0, bus cycles without ack before a bus fault is raised; 0 disables the timeout.
REQ-003 clk  in  1  clock; rstn  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid_i  in  1  instruction offered; ex_ready_o  out  1  instruction accepted when both high.
REQ-005 ex_load_i, ex_store_i  in  1 each  access type; both low means non-memory instruction.
REQ-006 ex_funct3_i  in  3  access size/sign; ex_addr_i  in  XLEN  byte address; ex_wdata_i  in  XLEN  store data.
REQ-007 ex_rd_addr_i  in  5; ex_rd_we_i  in  1; ex_rd_wdata_i  in  XLEN  non-memory result.
REQ-008 flush_i  in  1  kill the instruction being offered or held.
REQ-009 bus_req_o  out  1; bus_we_o  out  1; bus_addr_o  out  XLEN, aligned to XLEN/8; bus_wdata_o  out  XLEN; bus_be_o  out  XLEN/8.
REQ-010 bus_ack_i  in  1; bus_err_i  in  1; bus_rdata_i  in  XLEN.
REQ-011 wb_valid_o  out  1; wb_rd_addr_o  out  5; wb_rd_we_o  out  1; wb_rd_wdata_o  out  XLEN.
REQ-012 exc_valid_o  out  1; exc_cause_o  out  4; exc_addr_o  out  XLEN  faulting byte address.

Function
REQ-013 States are IDLE, BUS1 and BUS2; ex_ready_o SHALL be 1 only in IDLE with flush_i low.
REQ-014 An accepted non-memory instruction SHALL produce a wb_valid_o pulse with its rd fields on the next cycle.
REQ-015 An accepted load/store SHALL enter BUS1 with bus_req_o high from the next cycle.
REQ-016 bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o and bus_be_o SHALL stay stable until bus_ack_i or bus_err_i; one access outstanding at most.
REQ-017 Sizes: funct3 000/100 byte, 001/101 half, 010/110 word, 011 double; 1xx zero-extends and the others sign-extend.
REQ-018 Funct3 011, 110 or 111 when XLEN=32, or 111 when XLEN=64, SHALL raise an access fault (cause 5 load / 7 store) next cycle with no bus request.
REQ-019 Store data SHALL be shifted to the byte lane of the address; bus_be_o SHALL cover exactly the accessed bytes.
REQ-020 Load data SHALL be extracted from the addressed lanes and extended per REQ-017; stores SHALL write back with wb_rd_we_o=0.
REQ-021 The cycle after ack of the final beat, wb_valid_o SHALL pulse and the state SHALL return to IDLE; an aligned load has a minimum latency of 2 cycles from acceptance.
REQ-022 bus_err_i SHALL end the access and pulse exc_valid_o with cause 5 (load) or 7 (store), and no wb_valid_o.
REQ-023 When TIMEOUT>0 and TIMEOUT cycles elapse in BUS1/BUS2 without ack, the block SHALL drop bus_req_o and raise an access fault; if ack and timeout coincide, ack SHALL win.
REQ-024 wb_valid_o and exc_valid_o SHALL never be high together; each is a single-cycle pulse.
REQ-025 flush_i in BUS1/BUS2 during a load SHALL let the current beat finish, skip BUS2, and suppress wb_valid_o/exc_valid_o.
REQ-026 flush_i SHALL NOT abort an issued store: all beats complete, and only wb_valid_o/exc_valid_o are suppressed.
REQ-027 A misaligned access contained in one XLEN/8 word SHALL use a single beat with shifted bus_be_o.

Reset
REQ-028 On rstn low: state IDLE, timeout counter 0, all registered outputs 0; ex_ready_o 1 after release.
REQ-029 Reset in BUS1/BUS2 SHALL drop bus_req_o immediately and discard the access without writeback.

Configuration
REQ-030 Macro MEM_LSU_MISALIGN_SPLIT_EN defined: an access crossing an XLEN/8 boundary uses BUS1 at the aligned base and then BUS2 at base+XLEN/8, with load data merged from both beats.
REQ-031 With MEM_LSU_MISALIGN_SPLIT_EN undefined, any non-naturally-aligned access SHALL raise cause 4 (load) or 6 (store) next cycle, with no bus request.

Verification (XLEN=32)
REQ-032 LB 0x1003, rdata 0x80000000 -> bus_addr 0x1000, be 1000, wb_rd_wdata 0xFFFFFF80; LBU -> 0x00000080.
REQ-033 SH 0x1234ABCD at 0x2002 -> be 1100, wdata 0xABCD0000, bus_we 1, wb_valid with wb_rd_we 0.
REQ-034 LW 0x3002 with macro; beat 1 0x3000/be 1100/rdata 0x55667788, beat 2 0x3004/be 0011/rdata 0x11223344 -> 0x33445566; without macro -> exc cause 4, exc_addr 0x3002, no bus_req.
REQ-035 TIMEOUT=8, LW 0x4000, no ack -> bus_req drops after 8 cycles, exc cause 5, ex_ready 1 next cycle.
REQ-036 LW 0x5000, flush_i in BUS1, ack 3 cycles later -> no wb_valid/exc_valid, IDLE after ack; repeat as SW -> store completes with no wb_valid.
REQ-037 rstn low while in BUS2 -> bus_req_o 0 immediately, all outputs 0; a new LW after release completes normally.
